// File: rtl/imem_stream_pkg.sv
// Shared constants, state encoding and half-word helper for the tinysoc
// instruction-memory load streamer.
package imem_stream_pkg;

  localparam int WORDS      = 8;
  localparam int INSTR_W    = 12;
  localparam int HALF_W     = 6;
  localparam int HALF_IDX_W = $clog2(2 * WORDS);
  localparam int SLOT_W     = $clog2(WORDS);
  localparam int CNT_W      = $clog2(WORDS + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RESET,
    ST_STREAM
  } state_e;

  // The target loader expects the low half-word of each instruction first.
  function automatic logic [HALF_W-1:0] halfSelect(input logic [INSTR_W-1:0] instr,
                                                   input logic               upper);
    return upper ? instr[INSTR_W-1:HALF_W] : instr[HALF_W-1:0];
  endfunction

endpackage

// File: rtl/imem_streamer_buf.sv
// Instruction slot storage: written at the fill count, read by slot index,
// with slots not yet written since the last stream reading as zero.
module stream_buf
  import imem_stream_pkg::*;
(
  input  logic               clk_i,
  input  logic               we_i,
  input  logic [INSTR_W-1:0] wdata_i,
  input  logic [CNT_W-1:0]   count_i,
  input  logic [SLOT_W-1:0]  rd_slot_i,
  output logic [INSTR_W-1:0] rdata_o
);

  logic [INSTR_W-1:0] mem_q [WORDS];

  // Deliberately not reset: stale contents are hidden by the count mask.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[count_i[SLOT_W-1:0]] <= wdata_i;
    end
  end

  always_comb begin
    rdata_o = '0;
    if (CNT_W'(rd_slot_i) < count_i) begin
      rdata_o = mem_q[rd_slot_i];
    end
  end

endmodule

// File: rtl/imem_streamer.sv
// Host-side transmitter: buffers instructions, pulses the target reset, then
// streams every slot as two half-words on the gapless load bus.
module imem_streamer
  import imem_stream_pkg::*;
#(
  parameter int RST_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [INSTR_W-1:0] s_instr,
  input  logic               start,
  output logic               tgt_rst,
  output logic [HALF_W-1:0]  tgt_data,
  output logic               busy,
  output logic               done
);

  localparam int RST_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RST_W-1:0]      RST_LAST = RST_W'(RST_CYCLES - 1);
  localparam logic [HALF_IDX_W:0]   H_END    = (HALF_IDX_W + 1)'(2 * WORDS);
  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(WORDS);

  state_e              state_q;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    count_d;
  logic [HALF_IDX_W:0] h_q;
  logic [RST_W-1:0]    rstCnt_q;
  logic                tgt_rst_q;
  logic [HALF_W-1:0]   tgt_data_q;
  logic                s_ready_q;
  logic                busy_q;
  logic                done_q;

  logic                accept;
  logic [INSTR_W-1:0]  rdData;
  logic [HALF_W-1:0]   beat_d;

  assign accept  = (state_q == ST_IDLE) && s_valid && s_ready_q;
  assign count_d = count_q + CNT_W'(accept);
  assign beat_d  = halfSelect(rdData, h_q[0]);

  stream_buf u_buf (
    .clk_i     (clk),
    .we_i      (accept),
    .wdata_i   (s_instr),
    .count_i   (count_q),
    .rd_slot_i (h_q[HALF_IDX_W-1:1]),
    .rdata_o   (rdData)
  );

  // h_q always names the next beat to load, so the last RESET edge already
  // presents beat 0 and the target sees no idle cycle between reset and data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      h_q        <= '0;
      rstCnt_q   <= '0;
      tgt_rst_q  <= 1'b1;
      tgt_data_q <= '0;
      s_ready_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          count_q <= count_d;
          if (start) begin
            state_q    <= ST_RESET;
            rstCnt_q   <= '0;
            h_q        <= '0;
            tgt_rst_q  <= 1'b1;
            tgt_data_q <= '0;
            s_ready_q  <= 1'b0;
            busy_q     <= 1'b1;
          end else begin
            s_ready_q <= (count_d < CNT_FULL);
          end
        end

        ST_RESET: begin
          if (rstCnt_q == RST_LAST) begin
            state_q    <= ST_STREAM;
            tgt_rst_q  <= 1'b0;
            tgt_data_q <= beat_d;
            h_q        <= h_q + 1'b1;
          end else begin
            rstCnt_q <= rstCnt_q + 1'b1;
          end
        end

        ST_STREAM: begin
          if (h_q == H_END) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            tgt_data_q <= '0;
            s_ready_q  <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
          end else begin
            tgt_data_q <= beat_d;
            h_q        <= h_q + 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign s_ready  = s_ready_q;
  assign tgt_rst  = tgt_rst_q;
  assign tgt_data = tgt_data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: doc/imem_streamer.md
# imem_streamer

Host-side transmitter for the tinysoc instruction-memory load protocol. Buffers up to eight 12-bit instructions from an upstream valid/ready source. On `start`, it pulses the target's active-high reset. It then drives the 6-bit load bus for 16 consecutive cycles: low half-word then high half-word per instruction, address 0 first. Sits between a test host or boot source and the `io_in[7:1]` pins of the SoC, sharing its clock.

## Interface
- `WORDS`, 8: instruction slots; equals target imem depth.
- `INSTR_W`, 12: instruction width.
- `HALF_W`, 6: load-bus width; `INSTR_W == 2*HALF_W`.
- `RST_CYCLES`, 2: cycles `tgt_rst` is held high in RESET; must be ≥1.

Ports:
- `clk`, in, 1: single clock, also drives the target.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `s_valid`, in, 1: upstream instruction valid.
- `s_ready`, out, 1: streamer can accept an instruction.
- `s_instr`, in, `INSTR_W`: instruction, written to the next free slot.
- `start`, in, 1: begin the reset+stream sequence.
- `tgt_rst`, out, 1: target reset; wires to `io_in[1]`.
- `tgt_data`, out, `HALF_W`: load bus; wires to `io_in[7:2]`.
- `busy`, out, 1: high in RESET and STREAM.
- `done`, out, 1: one-cycle pulse after the last half-word.

## Operation
- States: IDLE, RESET, STREAM.
- IDLE:
  - `s_ready = (count < WORDS)`.
  - A handshake (`s_valid & s_ready`) writes `s_instr` to slot `count`; `count` increments.
  - `start` moves to RESET. Slots at or above `count` stream as 12'h000.
  - `start` with `count==0` is legal and streams all zeros.
- RESET:
  - `tgt_rst=1` for exactly `RST_CYCLES` cycles; `tgt_data=0`.
  - Then moves to STREAM with half index `h=0`.
- STREAM:
  - `tgt_rst=0`.
  - `tgt_data` = slot `h>>1`. Bits [5:0] when `h` is even, bits [11:6] when `h` is odd.
  - `h` runs 0..2·WORDS−1 with no gaps or stalls; the target loader has no valid qualifier.
  - After the final half-word: `done` pulses, `count` clears to 0, state returns to IDLE.
- `tgt_rst` stays 0 after streaming, so the target runs the loaded program. It reasserts only in the next RESET or on `rst_n`.
- `s_ready=0` and `start` is ignored while `busy`. Buffer contents are not modified during streaming.
- `s_valid` and `start` in the same IDLE cycle: the instruction is accepted first (if `s_ready`) and is included in the stream.
- Full buffer: `s_ready=0`; `s_valid` is ignored, not overwritten.

## Timing
- Reset values (asynchronous): state IDLE, `count=0`, `tgt_rst=1` (target held in reset), `tgt_data=0`, `s_ready=0`, `busy=0`, `done=0`.
  - `s_ready` rises the first cycle after `rst_n` deasserts.
- All outputs are registered, so the target samples clean values on the same `clk` edge.
- Cycle sequence from `start` sampled at edge T:
  - `tgt_rst` high during cycles T+1..T+RST_CYCLES.
  - First half-word on `tgt_data` in cycle T+RST_CYCLES+1, the first cycle with `tgt_rst` low.
  - Last half-word in cycle T+RST_CYCLES+2·WORDS.
  - `done` high in cycle T+RST_CYCLES+2·WORDS+1; `busy` low that same cycle.
- Total latency `start`→`done`: RST_CYCLES+2·WORDS+1 cycles (19 with defaults).
- `rst_n` asserted mid-stream aborts immediately: `tgt_rst` goes high asynchronously, the target resets, and the buffer count is lost.
- Buffer slots are not cleared by reset; unwritten slots are masked to zero by `count`.

## Structure
- Package `imem_stream_pkg`:
  - `WORDS`, `INSTR_W`, `HALF_W` localparams.
  - State enum `{ST_IDLE, ST_RESET, ST_STREAM}`.
  - Half-word select helper constant `HALF_IDX_W = $clog2(2*WORDS)`.
- Sub-module `stream_buf`:
  - `WORDS`×`INSTR_W` register array.
  - Write port at `count`, combinational read port at `h>>1`.
  - Zero-masking for slots ≥ `count`.
- The FSM, counters and output registers live in `imem_streamer`.

## Test plan
- **Full load:** write 8 instructions 12'h001..12'h008, then `start`.
  - `tgt_rst` high 2 cycles.
  - `tgt_data` sequence 01,00,02,00,…,08,00 with no gaps.
  - `done` pulse 19 cycles after `start`.
  - With a tinysoc model attached, `rom_done`=1 and imem[i]=i+1.
- **High-half ordering:** write 12'hABC to slot 0, 3 others, `start`.
  - First two beats are 6'h3C then 6'h2A.
  - Beats for slots 4..7 are all 0.
- **Backpressure:** hold `s_valid=1` for 10 cycles.
  - Exactly 8 accepted; `s_ready` drops after the 8th.
  - The 9th value never appears on the stream.
- **Simultaneous events:** `s_valid`+`start` in the same cycle with `count=7` → stream includes that 8th instruction.
  - `start` pulsed during STREAM is ignored; the beat sequence is unchanged.
- **Reset mid-stream:** drop `rst_n` at beat 5.
  - `tgt_rst`=1 before the next edge; `tgt_data`=0; `busy`=0; `count`=0.
  - A subsequent 8-word load and stream completes correctly.
